// File: rtl/idct_pkg.sv
// Shared constants for the two-stage 4x4 IDCT datapath. The transpose buffer
// uses the sample width, block size and clip range. The coefficient and
// rounding constants belong to the row and column stages.
package idct_pkg;

    // Sample width of first-stage results (signed two's complement).
    localparam int DW = 25;

    // Block dimension. Only 4 is supported by the transpose buffer.
    localparam int N = 4;

    // 4-point IDCT butterfly coefficients.
    localparam int COEF_64 = 64;
    localparam int COEF_83 = 83;
    localparam int COEF_36 = 36;

    // Rounding applied after each IDCT stage: (x + RND_ADD) >>> RND_SHIFT.
    localparam int RND_ADD   = 64;
    localparam int RND_SHIFT = 7;

    // Saturation range for intermediate samples (used when clipping is built in).
    localparam int CLIP_MIN = -32768;
    localparam int CLIP_MAX = 32767;

    // Index types for walking a 4x4 block.
    typedef logic [3:0] raster_idx_t;   // row-major position within a block
    typedef logic [1:0] col_idx_t;      // column (or row) index

endpackage

// File: rtl/idct_transpose_buf_if.sv
// Streaming bus for the IDCT transpose buffer. The sample input side uses
// valid/ready, and the column output side uses valid/ready plus a last marker.
// The slave modport is the buffer. The master modport is the producer and
// consumer pair around it.
interface idct_transpose_buf_if #(
    parameter int DW = idct_pkg::DW
);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_d1;
    logic [DW-1:0] out_d2;
    logic [DW-1:0] out_d3;
    logic [DW-1:0] out_d4;
    logic          out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_d1, out_d2, out_d3, out_d4, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_d1, out_d2, out_d3, out_d4, out_last
    );

endinterface

// File: rtl/tbuf_bank.sv
// One 4x4 storage bank of the transpose buffer. It has a single-sample write
// port addressed by (row, col) and a combinational read port that returns a
// whole column (rows 0..3) at once. Storage is kept in flops rather than RAM
// because every column read touches all four rows in the same cycle.
module tbuf_bank
    import idct_pkg::*;
#(
    parameter int DW = idct_pkg::DW,
    parameter int N  = idct_pkg::N
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  col_idx_t              wr_row,
    input  col_idx_t              wr_col,
    input  logic [DW-1:0]         wr_data,
    input  col_idx_t              rd_col,
    output logic [N-1:0][DW-1:0]  rd_data
);

    // Flat view of the cell registers for the column read mux.
    logic [DW-1:0] mem [N][N];

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                logic [DW-1:0] cell_q;
                logic [DW-1:0] cell_d;

                // Load the cell only when the write address selects it.
                always_comb begin
                    cell_d = cell_q;
                    if (wr_en && (wr_row == 2'(gi)) && (wr_col == 2'(gj))) begin
                        cell_d = wr_data;
                    end
                end

                // Cell register. Reset clears it so that stale data never leaks out.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        cell_q <= '0;
                    end else begin
                        cell_q <= cell_d;
                    end
                end

                assign mem[gi][gj] = cell_q;
            end

            // Column read: element gi of the column is row gi at rd_col.
            assign rd_data[gi] = mem[gi][rd_col];
        end
    endgenerate

endmodule

// File: rtl/idct_transpose_buf.sv
// Ping-pong 4x4 transpose buffer between the row and column IDCT stages.
// Samples arrive in row-major raster order, one per accepted beat. Once a
// bank holds 16 samples it is emitted column by column while the other bank
// fills, so the buffer sustains one sample per cycle when the consumer keeps
// up.
// Optional build macro IDCT_CLIP_EN: saturate incoming samples to
// [CLIP_MIN, CLIP_MAX] before storing. Without it, samples are stored at full
// width.
module idct_transpose_buf
    import idct_pkg::*;
#(
    parameter int DW = idct_pkg::DW,
    parameter int N  = idct_pkg::N     // only 4 is supported
) (
    input  logic                 clk,
    input  logic                 reset,
    idct_transpose_buf_if.slave  bus
);

    // Control state.
    raster_idx_t wr_cnt_q,  wr_cnt_d;    // raster position of the next write
    col_idx_t    rd_col_q,  rd_col_d;    // column currently presented
    logic        wr_bank_q, wr_bank_d;   // bank being filled
    logic        rd_bank_q, rd_bank_d;   // bank being drained
    logic [1:0]  full_q,    full_d;      // per-bank "holds a complete block"

    logic                 in_ready;
    logic                 out_valid;
    logic                 wr_fire;
    logic                 rd_fire;
    logic [DW-1:0]        store_data;
    logic [1:0]           bank_wr_en;
    logic [N-1:0][DW-1:0] bank_col [2];
    logic [N-1:0][DW-1:0] rd_col_data;

    // Handshakes. A bank accepts writes until it is full. The output is
    // valid whenever the read bank is full.
    always_comb begin
        in_ready  = !full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        wr_fire   = bus.in_valid && in_ready;
        rd_fire   = out_valid && bus.out_ready;
    end

    // Sample conditioning ahead of storage.
    always_comb begin
`ifdef IDCT_CLIP_EN
        if ($signed(bus.in_data) > $signed(DW'(CLIP_MAX))) begin
            store_data = DW'(CLIP_MAX);
        end else if ($signed(bus.in_data) < $signed(DW'(CLIP_MIN))) begin
            store_data = DW'(CLIP_MIN);
        end else begin
            store_data = bus.in_data;
        end
`else
        store_data = bus.in_data;
`endif
    end

    // Next-state logic. The write side and the read side update
    // independently. When both complete a block in the same cycle they
    // touch different full flags, because a full write bank would have
    // blocked the write.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_col_d  = rd_col_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 4'd1;            // wraps 15 -> 0
            if (wr_cnt_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        if (rd_fire) begin
            rd_col_d = rd_col_q + 2'd1;            // wraps 3 -> 0
            if (rd_col_q == 2'd3) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    // Control registers. An asynchronous reset drops any partly written or
    // partly read block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q  <= '0;
            rd_col_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_col_q  <= rd_col_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
        end
    end

    // Two storage banks. Only the bank selected by wr_bank sees the write.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_wr_en[gi] = wr_fire && (wr_bank_q == 1'(gi));

            tbuf_bank #(
                .DW (DW),
                .N  (N)
            ) u_bank (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (bank_wr_en[gi]),
                .wr_row  (wr_cnt_q[3:2]),
                .wr_col  (wr_cnt_q[1:0]),
                .wr_data (store_data),
                .rd_col  (rd_col_q),
                .rd_data (bank_col[gi])
            );
        end
    endgenerate

    // Present the current column of the read bank. Its value depends only
    // on registered state, so it holds still while the consumer stalls.
    always_comb begin
        rd_col_data   = rd_bank_q ? bank_col[1] : bank_col[0];
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid;
        bus.out_d1    = rd_col_data[0];
        bus.out_d2    = rd_col_data[1];
        bus.out_d3    = rd_col_data[2];
        bus.out_d4    = rd_col_data[3];
        bus.out_last  = (rd_col_q == 2'd3);
    end

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Directed bench for idct_transpose_buf. Inputs change on the falling edge
// and outputs are checked on the falling edge, half a cycle after the rising
// edge that updated them. Expected values are hand-derived transposes of the
// raster input.
module tb_idct_transpose_buf;

    localparam int DW = 25;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    idct_transpose_buf_if #(.DW(DW)) bus ();

    idct_transpose_buf #(.DW(DW), .N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Last-resort guard against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish within 200us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Drive n consecutive raster samples base..base+n-1, one per cycle.
    task automatic send_n(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(base + i);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for a column, check it with out_ready=1, then consume it.
    task automatic expect_col(input string tag, input int a, input int b,
                              input int c, input int d, input bit last);
        int w = 0;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && w < 40) begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        chk({tag, "_valid"}, DW'(bus.out_valid), DW'(1));
        chk({tag, "_d1"}, bus.out_d1, DW'(a));
        chk({tag, "_d2"}, bus.out_d2, DW'(b));
        chk({tag, "_d3"}, bus.out_d3, DW'(c));
        chk({tag, "_d4"}, bus.out_d4, DW'(d));
        chk({tag, "_last"}, DW'(bus.out_last), DW'(last));
        $display("col %s: %0d %0d %0d %0d last=%0d", tag, $signed(bus.out_d1),
                 $signed(bus.out_d2), $signed(bus.out_d3), $signed(bus.out_d4), bus.out_last);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready",  DW'(bus.in_ready),  DW'(1));
        chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("rst_out_last",  DW'(bus.out_last),  DW'(0));
        chk("rst_out_d1",    bus.out_d1,         DW'(0));
        reset = 1'b0;
        @(negedge clk);

        // Basic transpose of 0..15 with out_ready held high.
        bus.out_ready = 1'b1;
        send_n(0, 16);
        chk("t1_latency_valid", DW'(bus.out_valid), DW'(1));
        expect_col("t1_c0", 0, 4, 8, 12, 1'b0);
        expect_col("t1_c1", 1, 5, 9, 13, 1'b0);
        expect_col("t1_c2", 2, 6, 10, 14, 1'b0);
        expect_col("t1_c3", 3, 7, 11, 15, 1'b1);
        chk("t1_idle_valid", DW'(bus.out_valid), DW'(0));

        // Two blocks back to back with the consumer stalled.
        bus.out_ready = 1'b0;
        send_n(100, 16);
        send_n(200, 16);
        chk("t2_in_ready_low", DW'(bus.in_ready), DW'(0));
        chk("t2_out_valid",    DW'(bus.out_valid), DW'(1));
        // A write offered while not ready must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(999);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        expect_col("t2_b1_c0", 100, 104, 108, 112, 1'b0);
        expect_col("t2_b1_c1", 101, 105, 109, 113, 1'b0);
        expect_col("t2_b1_c2", 102, 106, 110, 114, 1'b0);
        expect_col("t2_b1_c3", 103, 107, 111, 115, 1'b1);
        chk("t2_in_ready_back", DW'(bus.in_ready), DW'(1));
        expect_col("t2_b2_c0", 200, 204, 208, 212, 1'b0);
        expect_col("t2_b2_c1", 201, 205, 209, 213, 1'b0);
        expect_col("t2_b2_c2", 202, 206, 210, 214, 1'b0);
        expect_col("t2_b2_c3", 203, 207, 211, 215, 1'b1);
        chk("t2_idle_valid", DW'(bus.out_valid), DW'(0));

        // out_ready toggles: each column is checked in the stall cycle and then accepted.
        bus.out_ready = 1'b0;
        send_n(50, 16);
        for (int c = 0; c < 4; c++) begin
            bus.out_ready = 1'b0;
            chk($sformatf("t3_c%0d_stall_d1", c), bus.out_d1, DW'(50 + c));
            chk($sformatf("t3_c%0d_stall_d4", c), bus.out_d4, DW'(62 + c));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("t3_c%0d_hold_valid", c), DW'(bus.out_valid), DW'(1));
            chk($sformatf("t3_c%0d_hold_d2", c), bus.out_d2, DW'(54 + c));
            chk($sformatf("t3_c%0d_hold_d3", c), bus.out_d3, DW'(58 + c));
            chk($sformatf("t3_c%0d_hold_last", c), DW'(bus.out_last), DW'(c == 3));
            $display("t3 column %0d held through stall", c);
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        chk("t3_idle_valid", DW'(bus.out_valid), DW'(0));

        // Out-of-range samples, with or without clipping.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(40000);
        @(posedge clk);
        @(negedge clk);
        bus.in_data   = DW'(-40000);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        send_n(2, 14);
`ifdef IDCT_CLIP_EN
        expect_col("t4_c0", 32767, 4, 8, 12, 1'b0);
        expect_col("t4_c1", -32768, 5, 9, 13, 1'b0);
`else
        expect_col("t4_c0", 40000, 4, 8, 12, 1'b0);
        expect_col("t4_c1", -40000, 5, 9, 13, 1'b0);
`endif
        expect_col("t4_c2", 2, 6, 10, 14, 1'b0);
        expect_col("t4_c3", 3, 7, 11, 15, 1'b1);

        // Reset after a partial block. Only the fresh block may appear.
        bus.out_ready = 1'b0;
        send_n(700, 7);
        reset = 1'b1;
        #1;
        chk("t5_rst_in_ready",  DW'(bus.in_ready),  DW'(1));
        chk("t5_rst_out_valid", DW'(bus.out_valid), DW'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_n(300, 16);
        expect_col("t5_c0", 300, 304, 308, 312, 1'b0);
        expect_col("t5_c1", 301, 305, 309, 313, 1'b0);
        expect_col("t5_c2", 302, 306, 310, 314, 1'b0);
        expect_col("t5_c3", 303, 307, 311, 315, 1'b1);
        chk("t5_idle_valid", DW'(bus.out_valid), DW'(0));

        // Block B's 16th write lands in the same cycle as block A's column-3 read.
        bus.out_ready = 1'b0;
        send_n(400, 16);
        send_n(500, 15);
        expect_col("t6_a_c0", 400, 404, 408, 412, 1'b0);
        expect_col("t6_a_c1", 401, 405, 409, 413, 1'b0);
        expect_col("t6_a_c2", 402, 406, 410, 414, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(515);
        expect_col("t6_a_c3", 403, 407, 411, 415, 1'b1);
        bus.in_valid = 1'b0;
        chk("t6_b_valid_next", DW'(bus.out_valid), DW'(1));
        chk("t6_b_first_d1",   bus.out_d1,         DW'(500));
        chk("t6_in_ready",     DW'(bus.in_ready),  DW'(1));
        expect_col("t6_b_c0", 500, 504, 508, 512, 1'b0);
        expect_col("t6_b_c1", 501, 505, 509, 513, 1'b0);
        expect_col("t6_b_c2", 502, 506, 510, 514, 1'b0);
        expect_col("t6_b_c3", 503, 507, 511, 515, 1'b1);
        chk("t6_idle_valid", DW'(bus.out_valid), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/idct_transpose_buf.md
IDCT_TRANSPOSE_BUF -- requirements
Module: idct_transpose_buf

Interface
REQ-001 SHALL have parameter DW, default 25: sample width, signed two's complement.
REQ-002 SHALL have parameter N, default 4: block dimension; only N=4 is supported.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data holds a first-stage IDCT result.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept in_data this cycle.
REQ-007 SHALL have port in_data, input, DW bits: signed sample, row-major raster order within each 4x4 block.
REQ-008 SHALL have port out_valid, output, 1 bit: out_d1..out_d4 hold one valid column.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream (second-stage IDCT) accepts the column.
REQ-010 SHALL have ports out_d1, out_d2, out_d3, out_d4, output, DW bits each: column elements for rows 0..3.
REQ-011 SHALL have port out_last, output, 1 bit: the current column is column 3 of the block.

Function
REQ-012 SHALL hold two 4x4 storage banks (ping-pong), each with a full flag.
REQ-013 SHALL drive in_ready = !full[wr_bank].
REQ-014 SHALL write in_data to bank[wr_bank][wr_cnt[3:2]][wr_cnt[1:0]] and increment 4-bit wr_cnt on each in_valid && in_ready.
REQ-015 SHALL, on an accepted write with wr_cnt==15, set full[wr_bank], toggle wr_bank and wrap wr_cnt to 0.
REQ-016 SHALL drive out_valid = full[rd_bank], so the first column is valid one cycle after the 16th sample is accepted.
REQ-017 SHALL drive out_dK = bank[rd_bank][K-1][rd_col], and out_last = (rd_col==3).
REQ-018 SHALL, on each out_valid && out_ready, increment 2-bit rd_col.
REQ-019 SHALL, when rd_col==3 is accepted, clear full[rd_bank], toggle rd_bank and wrap rd_col to 0.
REQ-020 SHALL keep out_d1..out_d4 and out_last stable while out_valid && !out_ready.
REQ-021 SHALL apply both updates when a block write completes and a block read completes in the same cycle; the banks differ, so there is no conflict.
REQ-022 SHALL sustain 1 input sample per cycle indefinitely when out_ready is held at 1.
REQ-023 SHALL ignore in_data and hold all state when in_valid=0 or in_ready=0.

Reset
REQ-024 SHALL, while reset=1, clear wr_cnt, rd_col, wr_bank, rd_bank, both full flags and all storage to 0.
REQ-025 SHALL therefore hold out_valid=0, out_last=0, out_d1..out_d4=0 and in_ready=1 while reset=1.
REQ-026 SHALL discard partially written or partially read blocks on reset mid-operation; no column is emitted from them.

Configuration
REQ-027 SHALL, with IDCT_CLIP_EN defined, saturate each accepted in_data to the range [-32768, 32767] before storing, sign-extending the result to DW.
REQ-028 SHALL, without IDCT_CLIP_EN, store in_data unmodified at full DW width.

Structure
REQ-029 SHALL take DW, N, the IDCT coefficients (64, 83, 36), the rounding constants (add 64, shift 7) and CLIP_MIN/CLIP_MAX from shared package idct_pkg.
REQ-030 SHALL instantiate sub-module tbuf_bank twice: a 4x4 DW-bit register array with a write port and a 4-element column read port.

Verification
REQ-031 SHALL cover: reset, then in_data = 0..15 on consecutive cycles with out_ready=1 -> columns (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15), with out_last on the 4th column only.
REQ-032 SHALL cover: two blocks streamed back to back with out_ready=0 -> in_ready drops after sample 32; raising out_ready releases block 1 then block 2 in order.
REQ-033 SHALL cover: out_ready toggling 1/0 every cycle -> each column holds stable during stall cycles; none lost or duplicated.
REQ-034 SHALL cover: with IDCT_CLIP_EN, inputs 40000 and -40000 -> outputs 32767 and -32768; without the macro -> 40000 and -40000.
REQ-035 SHALL cover: reset asserted after 7 samples, then a fresh 16-sample block -> only the fresh block is output.
REQ-036 SHALL cover: the 16th write of block B in the same cycle as the column-3 read of block A -> both flags update, and block B's first column is valid next cycle.
